scalling_in: RTL and testbench
==============================

// Module: scalling_in
// PURPOSE
//  Input-side counterpart of the output scaling stage in the 64-point FFT processor.
//  - Accepts complex samples from the source one at a time, using a valid/ready handshake.
//  - Applies the IFFT real/imag swap, latched once per frame.
//  - Counts samples into 64-point frames.
//  - Presents each sample with its (optionally bit-reversed) buffer address to the FFT input memory.
//  - The output stage undoes the swap and applies the 1/N scaling.
// PARAMETERS
//  DATA_WIDTH   32  packed complex width: real in [DATA_WIDTH-1:DATA_WIDTH/2], imag in low half
//  N_POINTS     64  samples per frame; must be a power of 2
//  ADDR_W       6   log2(N_POINTS)
//  BIT_REVERSE  1   1: Addr is the bit-reversed sample index; 0: Addr is the natural index
// PORTS
//  Clock        in   1           rising-edge clock
//  Reset        in   1           asynchronous, active-high reset
//  A32          in   DATA_WIDTH  input sample {real, imag}, two's complement halves
//  In_Valid     in   1           A32 is valid
//  In_Ready     out  1           block can accept A32 this cycle
//  Swap         in   1           1 = IFFT mode (swap real/imag); sampled only on a frame's first sample
//  Flush        in   1           synchronous abort of the current frame
//  R32          out  DATA_WIDTH  registered output sample
//  Addr         out  ADDR_W      write address for R32 in the FFT input buffer
//  Out_Valid    out  1           R32/Addr/flags are valid
//  Out_Ready    in   1           consumer accepts this cycle
//  Frame_Start  out  1           R32 is sample 0 of its frame
//  Frame_Last   out  1           R32 is sample N_POINTS-1 of its frame
//  Frame_Swap   out  1           swap mode in force for the frame being output
// BEHAVIOUR
//  Reset (async, while high): all outputs and internal state are cleared.
//  - R32, Addr, Out_Valid, Frame_Start, Frame_Last, Frame_Swap = 0.
//  - Sample counter cnt = 0; latched mode = 0.
//  - In_Ready = 1 immediately after reset is released.
//  Handshake:
//  - In_Ready = !Out_Valid | Out_Ready (combinational; one-stage pipeline, no bubble).
//  - Accept = In_Valid & In_Ready & !Flush.
//  - Out_Valid clears on Out_Valid & Out_Ready & !Accept.
//  - While Out_Valid & !Out_Ready, all outputs hold stable.
//  Latency: one cycle from accept to Out_Valid.
//  On accept:
//  - Effective mode m: Swap if cnt == 0, otherwise the latched mode.
//  - Mode is latched when cnt == 0; Swap changes mid-frame are ignored.
//  - R32 <= m ? {A32 low half, A32 high half} : A32. No arithmetic is applied; widths are preserved.
//  - Addr <= BIT_REVERSE ? bitrev(cnt) : cnt.
//  - Frame_Start <= (cnt == 0); Frame_Last <= (cnt == N_POINTS-1); Frame_Swap <= m.
//  - cnt <= cnt + 1, wrapping N_POINTS-1 -> 0. Back-to-back frames need no gap cycle.
//  Flush (sync, priority over accept in the same cycle):
//  - cnt <= 0 and Out_Valid <= 0; the presented sample, if any, is dropped.
//  - In_Ready is unaffected by Flush, but no sample is taken that cycle.
//  - The next accepted sample starts a new frame and re-samples Swap.
//  Simultaneous output pop and input accept: the new sample replaces the old one; Out_Valid stays 1.
//  Reset asserted mid-frame: partial frame discarded; the next frame starts at cnt = 0.
// TESTING
//  1. Reset, then stream 64 samples A32 = {i, -i} with Swap = 0, Out_Ready = 1.
//     -> R32 = A32 one cycle later; Addr = bitrev6(i) (sample 1 -> 32, sample 2 -> 16);
//        Frame_Start only on i = 0, Frame_Last only on i = 63.
//  2. Swap = 1 at sample 0, toggle Swap at sample 10, A32 = 32'h1234_ABCD.
//     -> R32 = 32'hABCD_1234 for all 64 samples; Frame_Swap = 1 throughout.
//  3. Hold Out_Ready = 0 for 5 cycles with In_Valid = 1.
//     -> In_Ready = 0 and outputs stable; no sample lost or duplicated once Out_Ready = 1.
//  4. Two frames back-to-back, first Swap = 0, second Swap = 1.
//     -> sample 63 of frame 1 is immediately followed by Frame_Start with Frame_Swap = 1; cnt wraps cleanly.
//  5. Flush at sample 20 with In_Valid = 1 in the same cycle.
//     -> that sample is dropped; next accept gives Frame_Start = 1, Addr = 0.
//  6. Assert Reset at sample 40, then resume.
//     -> all outputs 0 while Reset is high; first sample after release has Addr = 0 and Frame_Start = 1.

Source files
------------

// File: rtl/scalling_in.sv
// FFT input stage: IFFT real/imag swap latched per frame, frame counting, bit-reversed buffer address.
// One-cycle latency; single output register refilled in the pop cycle, so In_Ready = !Out_Valid | Out_Ready.
module scalling_in #(
  parameter int DATA_WIDTH  = 32,
  parameter int N_POINTS    = 64,
  parameter int ADDR_W      = 6,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] A32,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic                  Swap,
  input  logic                  Flush,
  output logic [DATA_WIDTH-1:0] R32,
  output logic [ADDR_W-1:0]     Addr,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic                  Frame_Start,
  output logic                  Frame_Last,
  output logic                  Frame_Swap
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] r32_q, r32_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  vld_q, vld_d;
  logic                  start_q, start_d;
  logic                  last_q, last_d;
  logic                  fswap_q, fswap_d;

  logic                  accept;
  logic                  first;
  logic                  mode_eff;
  logic [ADDR_W-1:0]     cnt_rev;

  assign In_Ready = !vld_q | Out_Ready;
  assign accept   = In_Valid & In_Ready & !Flush;
  assign first    = (cnt_q == '0);
  // Swap is only honoured on a frame's first sample; mid-frame toggles are ignored.
  assign mode_eff = first ? Swap : mode_q;

  always_comb begin
    cnt_rev = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      cnt_rev[b] = cnt_q[ADDR_W-1-b];
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    r32_d   = r32_q;
    addr_d  = addr_q;
    vld_d   = vld_q;
    start_d = start_q;
    last_d  = last_q;
    fswap_d = fswap_q;

    if (Flush) begin
      cnt_d = '0;
      vld_d = 1'b0;
    end else if (accept) begin
      if (first) begin
        mode_d = Swap;
      end
      r32_d   = mode_eff ? {A32[HALF-1:0], A32[DATA_WIDTH-1:HALF]} : A32;
      addr_d  = BIT_REVERSE ? cnt_rev : cnt_q;
      start_d = first;
      last_d  = (cnt_q == LAST_IDX);
      fswap_d = mode_eff;
      cnt_d   = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
      vld_d   = 1'b1;
    end else if (vld_q && Out_Ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      r32_q   <= '0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
      fswap_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      r32_q   <= r32_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      start_q <= start_d;
      last_q  <= last_d;
      fswap_q <= fswap_d;
    end
  end

  assign R32         = r32_q;
  assign Addr        = addr_q;
  assign Out_Valid   = vld_q;
  assign Frame_Start = start_q;
  assign Frame_Last  = last_q;
  assign Frame_Swap  = fswap_q;

endmodule

// File: tb/tb_scalling_in.sv
// Bench for scalling_in: directed scenarios plus random traffic, scored against a queue-based model.
module tb_scalling_in;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] A32 = '0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic        Swap = 1'b0;
  logic        Flush = 1'b0;
  logic [31:0] R32;
  logic [5:0]  Addr;
  logic        Out_Valid;
  logic        Out_Ready = 1'b1;
  logic        Frame_Start;
  logic        Frame_Last;
  logic        Frame_Swap;

  scalling_in dut (
    .Clock(Clock), .Reset(Reset), .A32(A32), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Swap(Swap), .Flush(Flush), .R32(R32), .Addr(Addr), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Frame_Start(Frame_Start), .Frame_Last(Frame_Last),
    .Frame_Swap(Frame_Swap)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] r;
    logic [5:0]  a;
    logic        s;
    logic        l;
    logic        w;
  } exp_t;

  exp_t pending[$];
  int   idx  = 0;   // position of the next accepted sample within its frame
  logic mode = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [5:0] bitrev6(input int x);
    int v = x;
    int r = 0;
    for (int k = 0; k < 6; k++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return 6'(r);
  endfunction

  // One clock cycle: drive inputs, check everything visible before the edge, advance the model.
  task automatic step(input logic iv, input logic [31:0] a, input logic sw,
                      input logic orr, input logic fl);
    logic exp_ir;
    logic acc;
    logic m;
    exp_t e;
    @(negedge Clock);
    In_Valid  = iv;
    A32       = a;
    Swap      = sw;
    Out_Ready = orr;
    Flush     = fl;
    #1;
    exp_ir = (pending.size() == 0) || orr;
    chk("in_ready", {31'd0, In_Ready}, {31'd0, exp_ir});
    chk("out_valid", {31'd0, Out_Valid}, {31'd0, pending.size() != 0});
    if (pending.size() != 0) begin
      chk("r32", R32, pending[0].r);
      chk("addr", {26'd0, Addr}, {26'd0, pending[0].a});
      chk("frame_start", {31'd0, Frame_Start}, {31'd0, pending[0].s});
      chk("frame_last", {31'd0, Frame_Last}, {31'd0, pending[0].l});
      chk("frame_swap", {31'd0, Frame_Swap}, {31'd0, pending[0].w});
    end
    acc = iv && exp_ir && !fl;
    if (fl) begin
      pending.delete();
      idx = 0;
    end else begin
      if (pending.size() != 0 && orr) void'(pending.pop_front());
      if (acc) begin
        if (idx == 0) mode = sw;
        m   = mode;
        e.r = m ? {a[15:0], a[31:16]} : a;
        e.a = bitrev6(idx);
        e.s = (idx == 0);
        e.l = (idx == 63);
        e.w = m;
        pending.push_back(e);
        idx = (idx + 1) % 64;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_r32"}, R32, 32'd0);
    chk({tag, "_addr"}, {26'd0, Addr}, 32'd0);
    chk({tag, "_flags"}, {28'd0, Out_Valid, Frame_Start, Frame_Last, Frame_Swap}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    In_Valid = 1'b0;
    Flush    = 1'b0;
    Reset    = 1'b1;
    #1;
    check_zero("rst_async");
    @(negedge Clock);
    check_zero("rst_hold");
    Reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, In_Ready}, 32'd1);
    pending.delete();
    idx  = 0;
    mode = 1'b0;
  endtask

  initial begin
    logic [15:0] hi;
    logic [15:0] lo;

    // Plain frame, natural data
    do_reset();
    for (int i = 0; i < 64; i++) begin
      hi = 16'(i);
      lo = 16'(0 - i);
      step(1'b1, {hi, lo}, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

    // IFFT frame with a mid-frame Swap toggle that must be ignored
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 32'h1234_ABCD, (i < 10) ? 1'b1 : 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("swap_frame_done_idx", idx, 0);

    // Backpressure: Out_Ready low for 5 cycles with input pending
    for (int i = 0; i < 3; i++) step(1'b1, 32'hA000_0000 + i, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'hBEEF_0000 + i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 61; i++) step(1'b1, 32'hC000_0000 + i, 1'b0, 1'b1, 1'b0);
    chk("bp_frame_wrap_idx", idx, 0);

    // Back-to-back frames, second in swap mode
    for (int i = 0; i < 128; i++) begin
      step(1'b1, $urandom, (i >= 64) ? 1'b1 : 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Flush at sample 20 with a valid sample presented
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 63; i++) step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame at sample 40, then a full frame
    for (int i = 0; i < 40; i++) step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("drain_empty", {31'd0, Out_Valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
